// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with registered result and iterative MULTU into HI/LO
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MULTU = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   multiplicand;
    logic [2*WIDTH-1:0] product;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   alu_value;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] product_next;
    logic               accept;

    assign accept = in_valid && in_ready;
    assign zero   = (result == '0);

    // Single-cycle operation datapath; unknown codes (and MULTU here) produce zero
    always_comb begin
        alu_value = '0;
        case (ALUctrl)
            OP_AND:  alu_value = a & b;
            OP_OR:   alu_value = a | b;
            OP_ADD:  alu_value = a + b;
            OP_SUB:  alu_value = a - b;
            OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  alu_value = ~(a | b);
            default: alu_value = '0;
        endcase
    end

    // One shift-add step: conditional add into the upper half keeping the carry, then shift right
    always_comb begin
        mul_sum      = {1'b0, product[2*WIDTH-1:WIDTH]} +
                       (product[0] ? {1'b0, multiplicand} : {(WIDTH+1){1'b0}});
        product_next = {mul_sum, product[WIDTH-1:1]};
    end

    // Control FSM plus all registered outputs (result, out_valid, HI/LO, handshake)
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            result       <= '0;
            hi           <= '0;
            lo           <= '0;
            multiplicand <= '0;
            product      <= '0;
            count        <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (ALUctrl == OP_MULTU) begin
                            state        <= S_MUL;
                            in_ready     <= 1'b0;
                            busy         <= 1'b1;
                            multiplicand <= a;
                            product      <= {{WIDTH{1'b0}}, b};
                            count        <= '0;
                        end else begin
                            result    <= alu_value;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    product <= product_next;
                    count   <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state     <= S_IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        hi        <= product_next[2*WIDTH-1:WIDTH];
                        lo        <= product_next[WIDTH-1:0];
                        result    <= product_next[WIDTH-1:0];
                        out_valid <= 1'b1;
                        count     <= '0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = 4'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUctrl   (alu_ctrl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        sx = x;
        sy = y;
        case (op)
            4'd0:    return x & y;
            4'd1:    return x | y;
            4'd2:    return x + y;
            4'd6:    return x - y;
            4'd7:    return (sx < sy) ? 32'd1 : 32'd0;
            4'd12:   return ~(x | y);
            default: return 32'd0;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one single-cycle op and check the result in the following cycle; in_valid is left high
    task automatic sop(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input string name);
        logic [31:0] exp;
        exp      = ref_alu(op, x, y);
        in_valid = 1'b1;
        alu_ctrl = op;
        a        = x;
        b        = y;
        cycle();
        n_checks++;
        if (out_valid !== 1'b1 || result !== exp || zero !== (exp == 0)) begin
            n_fail++;
            $display("FAIL %s: out_valid=%b result=%h zero=%b, required out_valid=1 result=%h zero=%b",
                     name, out_valid, result, zero, exp, (exp == 0));
        end
        n_checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL %s_hilo: hi=%h lo=%h, required hi=%h lo=%h", name, hi, lo, m_hi, m_lo);
        end
    endtask

    // Issue MULTU; optionally keep in_valid high throughout; checks latency, stall length and product
    task automatic run_mul(input logic [31:0] x, input logic [31:0] y, input bit hold, input string name);
        logic [63:0] p;
        int cyc;
        int lows;
        p        = {32'b0, x} * {32'b0, y};
        in_valid = 1'b1;
        alu_ctrl = 4'd3;
        a        = x;
        b        = y;
        cycle();
        cyc  = 1;
        lows = 0;
        if (!hold) in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        while (!out_valid && cyc < 100) begin
            if (!in_ready) lows++;
            if (busy === in_ready) lows = lows + 1000;
            cycle();
            cyc++;
            a = $urandom;
            b = $urandom;
        end
        n_checks++;
        if (cyc !== 33) begin
            n_fail++;
            $display("FAIL %s_latency: out_valid after %0d cycles, required 33", name, cyc);
        end
        n_checks++;
        if (lows !== 32) begin
            n_fail++;
            $display("FAIL %s_stall: stall count %0d, required 32", name, lows);
        end
        n_checks++;
        if (hi !== p[63:32] || lo !== p[31:0] || result !== p[31:0] || zero !== (p[31:0] == 0)) begin
            n_fail++;
            $display("FAIL %s_product: hi=%h lo=%h result=%h zero=%b, required hi=%h lo=%h",
                     name, hi, lo, result, zero, p[63:32], p[31:0]);
        end
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ready: in_ready=%b busy=%b, required 1 0", name, in_ready, busy);
        end
        m_hi = p[63:32];
        m_lo = p[31:0];
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        cycle();
        cycle();
        n_checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b1 ||
            busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: ov=%b res=%h zero=%b rdy=%b busy=%b hi=%h lo=%h, required 0 0 1 1 0 0 0",
                     out_valid, result, zero, in_ready, busy, hi, lo);
        end
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
    endtask

    task automatic test_add_sub();
        sop(4'd2, 32'd7, 32'd5, "add_7_5");
        sop(4'd6, 32'd5, 32'd5, "sub_5_5");
        sop(4'd2, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        in_valid = 1'b0;
        cycle();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_slt_nor();
        sop(4'd7, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        sop(4'd7, 32'd1, 32'hFFFF_FFFF, "slt_pos");
        sop(4'd12, 32'd0, 32'd0, "nor_zero");
        sop(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, "undef_op");
        in_valid = 1'b0;
    endtask

    task automatic test_multu();
        run_mul(32'hFFFF_FFFF, 32'd2, 1'b1, "mul_held");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_max");
    endtask

    task automatic test_reset_mid_mul();
        bit seen;
        in_valid = 1'b1;
        alu_ctrl = 4'd3;
        a        = 32'h0001_0003;
        b        = 32'h0000_0101;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: rdy=%b busy=%b hi=%h lo=%h ov=%b, required 1 0 0 0 0",
                     in_ready, busy, hi, lo, out_valid);
        end
        m_hi = '0;
        m_lo = '0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            cycle();
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL aborted_pulse: out_valid seen=%b, required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        run_mul(32'h0001_2345, 32'h0009_8765, 1'b0, "mul_pre");
        sop(4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, "b2b_and");
        sop(4'd1, 32'hF000_0001, 32'h0000_1000, "b2b_or");
        sop(4'd2, 32'h7FFF_FFFF, 32'h0000_0003, "b2b_add");
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        logic [3:0] codes [10] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd15, 4'd4, 4'd9, 4'd3};
        logic [3:0] op;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 150; i++) begin
            op = codes[$urandom_range(0, 9)];
            x  = $urandom;
            y  = ($urandom_range(0, 3) == 0) ? x : $urandom;
            if (op == 4'd3) run_mul(x, y, 1'b0, "rnd_mul");
            else sop(op, x, y, "rnd_op");
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                cycle();
            end
        end
        in_valid = 1'b0;
        cycle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add_sub();
        test_slt_nor();
        test_multu();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU, directly downstream of the ALU control decoder. It consumes the 4-bit ALUctrl code with two operands and produces a registered result and zero flag one cycle after accept. It also implements an iterative shift-add unsigned multiply (MULTU) into HI/LO registers, which stalls the input handshake while it runs. The branch logic and writeback mux consume its outputs.

Parameters:
WIDTH, 32, operand/result width in bits. Must be at least 2.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request present this cycle
in_ready  output  1  unit can accept an operation this cycle
ALUctrl  input  4  operation code from ALU control decoder
a  input  WIDTH  operand A (rs)
b  input  WIDTH  operand B (rt/immediate)
out_valid  output  1  result valid, single-cycle pulse
result  output  WIDTH  registered result
zero  output  1  high when result == 0 (decoded from the result register)
hi  output  WIDTH  HI register (upper product)
lo  output  WIDTH  LO register (lower product)
busy  output  1  multiply in progress (equals !in_ready)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, busy=0, out_valid=0, result=0, zero=1, hi=0, lo=0, iteration count=0.
- Accept: an operation is accepted when in_valid && in_ready at a rising edge. in_valid while in_ready=0 is ignored, not queued.
- Operation encoding (ALUctrl):
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT, signed compare: result = 1 if $signed(a) < $signed(b), else 0
  - 1100 NOR
  - 0011 MULTU
  - Any other code: result=0, out_valid still pulses.
- ADD/SUB: wrap modulo 2^WIDTH. No overflow flag, no trap.
- Single-cycle ops: result registered at the accept edge; out_valid=1 during the following cycle only. Back-to-back accepts each cycle give continuous out_valid. No downstream backpressure.
- Single-cycle ops never modify hi or lo.
- FSM states IDLE and MUL:
  - IDLE: in_ready=1.
  - IDLE to MUL: on accepting ALUctrl=0011. Load multiplicand=a. Load product[2*WIDTH-1:0] = {WIDTH'b0, b}. count=0.
  - MUL: in_ready=0, busy=1. Each cycle:
    - if product[0]=1, add multiplicand to product upper half, keeping the (WIDTH+1)-bit carry;
    - shift {carry, product} right by one;
    - count++.
  - MUL to IDLE: at the edge where count == WIDTH-1 (the WIDTH-th iteration). At that same edge: hi = final product upper half, lo = final product lower half, result = final lower half.
  - Following cycle: out_valid=1 and in_ready=1. A new op may be accepted in that cycle.
- MULTU latency: out_valid asserted WIDTH+1 cycles after the accept edge. in_ready=0 for exactly WIDTH cycles.
- Completion cycle: hi/lo may be read in the cycle out_valid pulses.
- MULTU result: the full unsigned 2*WIDTH product; it never overflows.
- Reset mid-multiply: aborts. Next cycle is IDLE with hi=lo=0 and no out_valid.
- zero tracks the result register at all times, including after MULTU (zero reflects lo).
- Operand inputs are sampled only at the accept edge. Changes during MUL have no effect.

Test Plan:
1. Reset asserted 2 cycles -> out_valid=0, result=0, zero=1, in_ready=1, busy=0, hi=lo=0.
2. ADD a=7, b=5 -> next cycle out_valid=1, result=12, zero=0. Then SUB a=5, b=5 -> result=0, zero=1. Then ADD 0xFFFFFFFF+1 -> result=0 (wrap), zero=1.
3. SLT a=0xFFFFFFFF, b=1 -> result=1. SLT a=1, b=0xFFFFFFFF -> result=0. NOR a=0, b=0 -> 0xFFFFFFFF. Undefined code 1111 -> result=0, out_valid=1.
4. MULTU a=0xFFFFFFFF, b=2 with in_valid held high throughout -> in_ready=0 for exactly 32 cycles, with no accepts during that time. out_valid pulses 33 cycles after accept with hi=0x00000001, lo=result=0xFFFFFFFE. The held request is accepted in the out_valid cycle. Also MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
5. Reset asserted 10 cycles into a MULTU -> next cycle in_ready=1, busy=0, hi=lo=0, no out_valid pulse ever appears for the aborted op.
6. Back-to-back AND, OR, ADD on consecutive cycles -> out_valid high 3 consecutive cycles with the correct results in order. hi/lo stay unchanged from the prior MULTU.
